// File: rtl/timer_irq.sv
// timer_irq: programmable down-counting bus timer; raises a level IRQ on terminal count until software writes CTRL/PRESET.
// Define TIMER_PRESCALE_EN to add the PSC prescaler register at Addr 3.
module timer_irq #(
    parameter int CNT_W = 32,
    parameter int PSC_W = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  Addr,
    input  logic        We,
    input  logic [31:0] DIn,
    output logic [31:0] DOut,
    output logic        IRQ
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CNT  = 2'd2
    } state_e;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_PRESET = 2'd1;
    localparam logic [1:0] ADDR_COUNT  = 2'd2;
    localparam logic [1:0] ADDR_PSC    = 2'd3;
    localparam logic [1:0] MODE_RELOAD = 2'b01;

    state_e           state_q, state_d;
    logic             en_q, en_d;
    logic [1:0]       mode_q, mode_d;
    logic             im_q, im_d;
    logic [CNT_W-1:0] preset_q, preset_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             pending_q, pending_d;

    logic             ctrl_wr;
    logic             preset_wr;
    logic             tick;
    logic             term_hit;
    logic             hw_en_clr;
    logic [PSC_W-1:0] psc_val;

    assign ctrl_wr   = We && (Addr == ADDR_CTRL);
    assign preset_wr = We && (Addr == ADDR_PRESET);

`ifdef TIMER_PRESCALE_EN
    logic [PSC_W-1:0] psc_q, psc_d;
    logic [PSC_W-1:0] psc_cnt_q, psc_cnt_d;

    // The counting stage only acts on the cycle the prescaler wraps.
    assign tick    = (psc_cnt_q == psc_q);
    assign psc_val = psc_q;

    always_comb begin
        psc_d     = psc_q;
        psc_cnt_d = psc_cnt_q;
        if (We && (Addr == ADDR_PSC)) begin
            psc_d = DIn[PSC_W-1:0];
        end
        if (state_q == LOAD) begin
            psc_cnt_d = '0;
        end else if (state_q == CNT) begin
            psc_cnt_d = tick ? '0 : psc_cnt_q + PSC_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            psc_q     <= '0;
            psc_cnt_q <= '0;
        end else begin
            psc_q     <= psc_d;
            psc_cnt_q <= psc_cnt_d;
        end
    end
`else
    assign tick    = 1'b1;
    assign psc_val = '0;
`endif

    // Terminal check comes before the decrement, so COUNT never wraps below zero.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        term_hit  = 1'b0;
        hw_en_clr = 1'b0;
        case (state_q)
            IDLE: begin
                if (en_q) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                count_d = preset_q;
                state_d = CNT;
            end
            CNT: begin
                if (!en_q) begin
                    state_d = IDLE;
                end else if (tick) begin
                    if (count_q != '0) begin
                        count_d = count_q - CNT_W'(1);
                    end else begin
                        term_hit = 1'b1;
                        if (mode_q == MODE_RELOAD) begin
                            state_d = LOAD;
                        end else begin
                            hw_en_clr = 1'b1;
                            state_d   = IDLE;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Software CTRL writes override the hardware EN clear; a terminal count overrides a pending clear.
    always_comb begin
        en_d      = en_q;
        mode_d    = mode_q;
        im_d      = im_q;
        preset_d  = preset_q;
        pending_d = pending_q;
        if (hw_en_clr) begin
            en_d = 1'b0;
        end
        if (ctrl_wr) begin
            en_d   = DIn[0];
            mode_d = DIn[2:1];
            im_d   = DIn[3];
        end
        if (preset_wr) begin
            preset_d = DIn[CNT_W-1:0];
        end
        if (term_hit) begin
            pending_d = 1'b1;
        end else if (ctrl_wr || preset_wr) begin
            pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            en_q      <= 1'b0;
            mode_q    <= 2'b00;
            im_q      <= 1'b0;
            preset_q  <= '0;
            count_q   <= '0;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            en_q      <= en_d;
            mode_q    <= mode_d;
            im_q      <= im_d;
            preset_q  <= preset_d;
            count_q   <= count_d;
            pending_q <= pending_d;
        end
    end

    always_comb begin
        case (Addr)
            ADDR_CTRL:   DOut = {28'b0, im_q, mode_q, en_q};
            ADDR_PRESET: DOut = 32'(preset_q);
            ADDR_COUNT:  DOut = 32'(count_q);
            default:     DOut = 32'(psc_val);
        endcase
    end

    assign IRQ = pending_q & im_q;

endmodule

// File: tb/tb_timer_irq.sv
// tb_timer_irq: randomized bus traffic against a timeline model of the timer, plus hand-computed directed checks.
module tb_timer_irq;

    localparam int CNT_W = 32;
    localparam int PSC_W = 8;
`ifdef TIMER_PRESCALE_EN
    localparam bit HAS_PSC = 1'b1;
`else
    localparam bit HAS_PSC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  Addr;
    logic        We;
    logic [31:0] DIn;
    logic [31:0] DOut;
    logic        IRQ;

    int nChecks = 0;
    int nPassed = 0;

    always #5 clk = ~clk;

    timer_irq #(.CNT_W(CNT_W), .PSC_W(PSC_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .Addr  (Addr),
        .We    (We),
        .DIn   (DIn),
        .DOut  (DOut),
        .IRQ   (IRQ)
    );

    // Model: a run is described by its load edge, loaded value and divider; COUNT is derived arithmetically.
    // phase: 0 stopped, 1 reload scheduled for the next edge, 2 running.
    int               phase;
    bit               mEn, mIm, mPending;
    bit [1:0]         mMode;
    logic [31:0]      mPreset, mCount, mLoaded;
    logic [PSC_W-1:0] mPsc;
    longint           edgeNo, mLoadEdge, mD;

    task automatic modelReset();
        phase     = 0;
        mEn       = 1'b0;
        mIm       = 1'b0;
        mMode     = 2'b00;
        mPending  = 1'b0;
        mPreset   = '0;
        mCount    = '0;
        mLoaded   = '0;
        mPsc      = '0;
        mLoadEdge = 0;
        mD        = 1;
    endtask

    task automatic modelStep(input bit w, input logic [1:0] a, input logic [31:0] d);
        bit     terminal;
        bit     hwClr;
        longint k;
        terminal = 1'b0;
        hwClr    = 1'b0;
        edgeNo++;
        case (phase)
            0: if (mEn) phase = 1;
            1: begin
                mLoaded   = mPreset;
                mLoadEdge = edgeNo;
                mD        = longint'(mPsc) + 1;
                phase     = 2;
            end
            default: begin
                k = edgeNo - mLoadEdge;
                if (!mEn) begin
                    phase = 0;
                end else if (k == (longint'(mLoaded) + 1) * mD) begin
                    terminal = 1'b1;
                    mCount   = '0;
                    if (mMode == 2'b01) begin
                        phase = 1;
                    end else begin
                        hwClr = 1'b1;
                        phase = 0;
                    end
                end
            end
        endcase
        if (phase == 2) mCount = mLoaded - 32'((edgeNo - mLoadEdge) / mD);
        if (terminal) mPending = 1'b1;
        else if (w && (a == 2'd0 || a == 2'd1)) mPending = 1'b0;
        if (hwClr) mEn = 1'b0;
        if (w) begin
            case (a)
                2'd0: {mIm, mMode, mEn} = d[3:0];
                2'd1: mPreset = d;
                2'd3: if (HAS_PSC) mPsc = d[PSC_W-1:0];
                default: ;
            endcase
        end
    endtask

    function automatic logic [31:0] modelRead(input logic [1:0] a);
        case (a)
            2'd0:    return {28'b0, mIm, mMode, mEn};
            2'd1:    return mPreset;
            2'd2:    return mCount;
            default: return HAS_PSC ? 32'(mPsc) : 32'd0;
        endcase
    endfunction

    initial begin
        edgeNo = 0;
        modelReset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) modelReset();
            else modelStep(We, Addr, DIn);
        end
    end

    task automatic checkVal(input string name, input logic [31:0] got, input logic [31:0] want);
        nChecks++;
        if (got === want) nPassed++;
        else $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, got, want, $time);
    endtask

    task automatic checkOutput();
        checkVal($sformatf("model_read_addr%0d", Addr), DOut, modelRead(Addr));
        checkVal("model_irq", {31'b0, IRQ}, {31'b0, mPending & mIm});
    endtask

    initial begin
        forever begin
            @(negedge clk);
            checkOutput();
        end
    end

    task automatic applyStimulus(input bit w, input logic [1:0] a, input logic [31:0] d);
        @(posedge clk);
        #1;
        We   = w;
        Addr = a;
        DIn  = d;
    endtask

    task automatic busWrite(input logic [1:0] a, input logic [31:0] d);
        applyStimulus(1'b1, a, d);
    endtask

    task automatic waitEdges(input int n, input logic [1:0] a);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, a, 32'd0);
    endtask

    task automatic checkNow(input string name, input logic [31:0] wantDout, input bit wantIrq);
        #1;
        checkVal({name, "_dout"}, DOut, wantDout);
        checkVal({name, "_irq"}, {31'b0, IRQ}, {31'b0, wantIrq});
    endtask

    task automatic stopTimer();
        busWrite(2'd0, 32'd0);
        waitEdges(3, 2'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        We    = 1'b0;
        Addr  = 2'd0;
        DIn   = 32'd0;
        @(negedge clk);
        #1;
        for (int a = 0; a < 4; a++) begin
            Addr = 2'(a);
            checkNow($sformatf("reset_addr%0d", a), 32'd0, 1'b0);
        end
        @(negedge clk);
        #2 rst_n = 1'b1;

        // One-shot, PRESET=5: COUNT=5 after E2, IRQ after E8, EN self-cleared.
        busWrite(2'd1, 32'd5);
        busWrite(2'd0, 32'h9);
        applyStimulus(1'b0, 2'd2, 32'd0);
        waitEdges(2, 2'd2);
        checkNow("oneshot_load", 32'd5, 1'b0);
        waitEdges(5, 2'd2);
        checkNow("oneshot_e7", 32'd0, 1'b0);
        applyStimulus(1'b0, 2'd0, 32'd0);
        checkNow("oneshot_e8", 32'h8, 1'b1);
        busWrite(2'd0, 32'h8);
        applyStimulus(1'b0, 2'd0, 32'd0);
        checkNow("oneshot_clear", 32'h8, 1'b0);
        stopTimer();

        // Auto-reload, PRESET=3: IRQ after E6, reload to 3 after E7, next terminal after E11.
        busWrite(2'd1, 32'd3);
        busWrite(2'd0, 32'hB);
        applyStimulus(1'b0, 2'd2, 32'd0);
        waitEdges(5, 2'd2);
        checkNow("reload_e5", 32'd0, 1'b0);
        waitEdges(1, 2'd2);
        checkNow("reload_e6", 32'd0, 1'b1);
        waitEdges(1, 2'd2);
        checkNow("reload_e7", 32'd3, 1'b1);
        busWrite(2'd0, 32'hB);
        applyStimulus(1'b0, 2'd2, 32'd0);
        checkNow("reload_clr_e9", 32'd1, 1'b0);
        waitEdges(1, 2'd2);
        checkNow("reload_e10", 32'd0, 1'b0);
        waitEdges(1, 2'd2);
        checkNow("reload_e11", 32'd0, 1'b1);
        stopTimer();

        // Masked one-shot, then unmasking write clears and restarts.
        busWrite(2'd1, 32'd2);
        busWrite(2'd0, 32'h1);
        applyStimulus(1'b0, 2'd0, 32'd0);
        waitEdges(5, 2'd0);
        checkNow("mask_term", 32'h0, 1'b0);
        busWrite(2'd0, 32'h9);
        applyStimulus(1'b0, 2'd0, 32'd0);
        checkNow("mask_clear", 32'h9, 1'b0);
        waitEdges(5, 2'd0);
        checkNow("mask_rerun", 32'h8, 1'b1);
        stopTimer();

        // PRESET write on the terminal edge: set wins.
        busWrite(2'd1, 32'd2);
        busWrite(2'd0, 32'h9);
        applyStimulus(1'b0, 2'd0, 32'd0);
        waitEdges(3, 2'd0);
        busWrite(2'd1, 32'd7);
        applyStimulus(1'b0, 2'd0, 32'd0);
        checkNow("collide_set_wins", 32'h8, 1'b1);
        stopTimer();

        // PRESET write mid-count only affects the next reload.
        busWrite(2'd1, 32'd4);
        busWrite(2'd0, 32'hB);
        applyStimulus(1'b0, 2'd2, 32'd0);
        waitEdges(2, 2'd2);
        checkNow("midwr_e2", 32'd4, 1'b0);
        busWrite(2'd1, 32'd1);
        applyStimulus(1'b0, 2'd2, 32'd0);
        checkNow("midwr_e4", 32'd2, 1'b0);
        waitEdges(4, 2'd2);
        checkNow("midwr_reload", 32'd1, 1'b1);
        stopTimer();

`ifdef TIMER_PRESCALE_EN
        busWrite(2'd3, 32'd1);
        busWrite(2'd1, 32'd2);
        busWrite(2'd0, 32'h9);
        applyStimulus(1'b0, 2'd2, 32'd0);
        waitEdges(3, 2'd2);
        checkNow("psc_e3", 32'd2, 1'b0);
        waitEdges(1, 2'd2);
        checkNow("psc_e4", 32'd1, 1'b0);
        stopTimer();
`else
        busWrite(2'd3, 32'hFF);
        applyStimulus(1'b0, 2'd3, 32'd0);
        checkNow("psc_absent", 32'd0, 1'b0);
`endif

        // Asynchronous reset mid-count with COUNT=7.
        busWrite(2'd1, 32'd9);
        busWrite(2'd0, 32'h1);
        applyStimulus(1'b0, 2'd2, 32'd0);
        waitEdges(4, 2'd2);
        checkNow("prereset_count", 32'd7, 1'b0);
        rst_n = 1'b0;
        checkNow("async_rst_count", 32'd0, 1'b0);
        Addr = 2'd0;
        checkNow("async_rst_ctrl", 32'd0, 1'b0);
        @(negedge clk);
        #2 rst_n = 1'b1;

        for (int i = 0; i < 3000; i++) begin
            bit          w;
            logic [1:0]  a;
            logic [31:0] d;
            w = ($urandom_range(0, 5) == 0);
            a = 2'($urandom_range(0, 3));
            if (a == 2'd1) d = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 6));
            else d = $urandom;
            if (HAS_PSC && a == 2'd3) w = 1'b0;
            applyStimulus(w, a, d);
        end

        @(negedge clk);
        #1;
        $display("[TB] %0d/%0d checks passed", nPassed, nChecks);
        $finish;
    end

endmodule
